// File: rtl/mips_run_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_run_ctrl_if : host command, breakpoint and core commit bus  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mips_run_ctrl_if #(
  parameter int STEP_W = 16
);
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;
  logic              cmd_ready;
  logic              cmd_err;
  logic              bp_en;
  logic [31:0]       bp_addr;
  logic [31:0]       pc;
  logic [31:0]       instr;
  logic              pc_en;
  logic [1:0]        run_state;
  logic [2:0]        halt_cause;
  logic [31:0]       cycle_cnt;
  logic [31:0]       retired_cnt;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, bp_en, bp_addr, pc, instr,
    input  cmd_ready, cmd_err, pc_en, run_state, halt_cause, cycle_cnt, retired_cnt
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, bp_en, bp_addr, pc, instr,
    output cmd_ready, cmd_err, pc_en, run_state, halt_cause, cycle_cnt, retired_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_run_ctrl : run/halt/step controller gating core commits     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mips_run_ctrl #(
  parameter bit RESET_RUN = 1'b0,
  parameter int STEP_W    = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mips_run_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {
    S_HALTED = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10
  } state_e;

  localparam logic [1:0]        c_OP_RUN   = 2'b00;
  localparam logic [1:0]        c_OP_HALT  = 2'b01;
  localparam logic [1:0]        c_OP_STEP  = 2'b10;
  localparam logic [1:0]        c_OP_CLEAR = 2'b11;
  localparam logic [2:0]        c_CAUSE_HOST    = 3'd1;
  localparam logic [2:0]        c_CAUSE_STEP    = 3'd2;
  localparam logic [2:0]        c_CAUSE_BREAK   = 3'd3;
  localparam logic [2:0]        c_CAUSE_SYSCALL = 3'd4;
  localparam logic [31:0]       c_SYSCALL = 32'h0000_000C;
  localparam logic [STEP_W-1:0] c_ONE     = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam state_e            c_RESET_STATE = RESET_RUN ? S_RUN : S_HALTED;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_left_q, step_left_d;
  logic              skip_q, skip_d;
  logic              cmd_err_q, cmd_err_d;
  logic [2:0]        halt_cause_q, halt_cause_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       retired_q, retired_d;

  logic w_is_sys;
  logic w_stop_now;
  logic w_active;
  logic w_pc_en;

  assign w_is_sys   = (bus.instr == c_SYSCALL);
  assign w_stop_now = !skip_q && ((bus.bp_en && (bus.pc == bus.bp_addr)) || w_is_sys);
  assign w_active   = (state_q != S_HALTED);
  assign w_pc_en    = reset && w_active && !w_stop_now;

  assign bus.cmd_ready   = 1'b1;
  assign bus.cmd_err     = cmd_err_q;
  assign bus.pc_en       = w_pc_en;
  assign bus.run_state   = state_q;
  assign bus.halt_cause  = halt_cause_q;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.retired_cnt = retired_q;

  always_comb begin
    state_d      = state_q;
    step_left_d  = step_left_q;
    skip_d       = skip_q;
    cmd_err_d    = 1'b0;
    halt_cause_d = halt_cause_q;
    cycle_d      = cycle_q + {31'b0, w_active};
    retired_d    = retired_q + {31'b0, w_pc_en};

    if (state_q == S_HALTED) begin
      if (bus.cmd_valid && bus.cmd_op == c_OP_RUN) begin
        state_d = S_RUN;
        skip_d  = 1'b1;
      end else if (bus.cmd_valid && bus.cmd_op == c_OP_STEP) begin
        state_d     = S_STEP;
        skip_d      = 1'b1;
        step_left_d = (bus.cmd_arg == '0) ? c_ONE : bus.cmd_arg;
      end
    end else begin
      // Later assignments override earlier ones: HOST > SYSCALL > BREAK > STEP_DONE.
      if (w_pc_en) begin
        skip_d = 1'b0;
        if (state_q == S_STEP) begin
          if (step_left_q == c_ONE) begin
            state_d      = S_HALTED;
            halt_cause_d = c_CAUSE_STEP;
          end else begin
            step_left_d = step_left_q - c_ONE;
          end
        end
      end
      if (w_stop_now) begin
        state_d      = S_HALTED;
        halt_cause_d = w_is_sys ? c_CAUSE_SYSCALL : c_CAUSE_BREAK;
      end
      if (bus.cmd_valid && bus.cmd_op == c_OP_HALT) begin
        state_d      = S_HALTED;
        halt_cause_d = c_CAUSE_HOST;
      end
      if (bus.cmd_valid && (bus.cmd_op == c_OP_RUN || bus.cmd_op == c_OP_STEP)) begin
        cmd_err_d = 1'b1;
      end
    end

    if (bus.cmd_valid && bus.cmd_op == c_OP_CLEAR) begin
      cycle_d   = '0;
      retired_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= c_RESET_STATE;
      step_left_q  <= '0;
      skip_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
      halt_cause_q <= '0;
      cycle_q      <= '0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      step_left_q  <= step_left_d;
      skip_q       <= skip_d;
      cmd_err_q    <= cmd_err_d;
      halt_cause_q <= halt_cause_d;
      cycle_q      <= cycle_d;
      retired_q    <= retired_d;
    end
  end
endmodule
`default_nettype wire

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Run controller for the single-cycle MIPS core: decides each cycle whether the datapath may commit an instruction. It drives one enable (`pc_en`) that gates the PC register update, the register-file write enable and the data-memory write enable. It accepts host commands (RUN, HALT, STEP n, CLEAR_STATS), stops on a PC breakpoint or a SYSCALL, and keeps cycle and retired-instruction counters for debug. It sits beside `mips_monociclo`, between the testbench/debug host and the core's commit enables.

## Interface

Parameters:
- `RESET_RUN`, default 0: state after reset. 0 = HALTED, 1 = RUN.
- `STEP_W`, default 16: width of the step-count argument.

Ports:
- `clk`  in  1: system clock. All state changes on the rising edge.
- `reset`  in  1: one clock; reset is synchronous and active-low (`reset`=0 resets on the next rising edge of `clk`).
- `cmd_valid`  in  1: host command strobe.
- `cmd_op`  in  2: 00 RUN, 01 HALT, 10 STEP, 11 CLEAR_STATS.
- `cmd_arg`  in  STEP_W: step count for STEP. 0 is treated as 1.
- `cmd_ready`  out  1: constant 1. Every command is consumed in the cycle `cmd_valid`=1.
- `cmd_err`  out  1: one-cycle registered pulse when the accepted command is illegal in the current state.
- `bp_en`  in  1: breakpoint enable.
- `bp_addr`  in  32: breakpoint PC.
- `pc`  in  32: current PC of the core.
- `instr`  in  32: current instruction of the core.
- `pc_en`  out  1: commit enable to the core. Combinational.
- `run_state`  out  2: 00 HALTED, 01 RUN, 10 STEP.
- `halt_cause`  out  3: 0 RESET, 1 HOST, 2 STEP_DONE, 3 BREAK, 4 SYSCALL.
- `cycle_cnt`  out  32: number of cycles spent in RUN or STEP.
- `retired_cnt`  out  32: number of cycles with `pc_en`=1.

## Operation

Commit enable:
- `stop_now` = `!skip` && ((`bp_en` && `pc`==`bp_addr`) || `instr`==32'h0000000C).
- `pc_en` = `reset` && (`run_state`!=HALTED) && !`stop_now`.

Skip flag:
- `skip` is set on every accepted RUN or STEP that leaves HALTED.
- `skip` is cleared on the first edge with `pc_en`=1.
- Effect: the instruction at a breakpoint or SYSCALL commits on resume. The core treats SYSCALL as a NOP.

FSM transitions (a transition without a stated cause leaves `halt_cause` unchanged):
- HALTED + RUN → RUN.
- HALTED + STEP → STEP, with `step_left` = max(`cmd_arg`, 1).
- HALTED + HALT: no effect, no error.
- RUN or STEP + `stop_now` → HALTED. Cause is SYSCALL if the SYSCALL opcode matches, else BREAK.
- STEP with `pc_en`=1 and `step_left`==1 → HALTED, cause STEP_DONE. Otherwise `step_left` decrements by 1 when `pc_en`=1.
- RUN or STEP + HALT → HALTED, cause HOST. The instruction committing in that same cycle still commits.
- RUN or STEP + RUN or STEP: ignored, `cmd_err`=1 on the next cycle.

Simultaneous stop sources: cause priority is HOST > SYSCALL > BREAK > STEP_DONE.

Counters:
- Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- `cycle_cnt` increments on each edge where `run_state`!=HALTED.
- `retired_cnt` increments on each edge where `pc_en`=1.
- CLEAR_STATS is legal in any state and never flags an error. It zeroes both counters at the next edge; a clear beats a same-cycle increment.

Reset values (`reset`=0 sampled at an edge):
- `run_state` = RUN if `RESET_RUN` else HALTED.
- `halt_cause` = 0, `cycle_cnt` = 0, `retired_cnt` = 0.
- `step_left` = 0, `skip` = 0, `cmd_err` = 0.
- A reset in the middle of RUN or STEP aborts it. `pc_en` is forced to 0 during every cycle in which `reset`=0, and a command presented in that cycle is dropped.

## Timing

- Command-to-effect latency is 1 edge. For example, a RUN accepted at edge k gives `run_state`=RUN and `pc_en`=1 in the cycle after k.
- `pc_en` follows `pc`, `instr`, `bp_*` combinationally within the same cycle. No instruction at a stop point ever commits without `skip`.
- STEP n commits exactly n instructions (fewer if a stop or HALT intervenes), then `run_state`=HALTED.
- `cmd_err`, `halt_cause` and the counters are registered and valid from the cycle after the causing edge.

## Test plan

- Reset with `RESET_RUN`=0, then RUN with the breakpoint off on a straight-line program → `pc_en`=1 every cycle. After 10 cycles, `cycle_cnt`=`retired_cnt`=10.
- `bp_en`=1, `bp_addr`=0x00000010, RUN from 0 → 4 commits, HALTED with `halt_cause`=3 and PC held at 0x10. A second RUN → the instruction at 0x10 commits, and RUN continues past it.
- Halted, STEP with `cmd_arg`=3 → exactly 3 `pc_en` pulses, then HALTED, `halt_cause`=2, `retired_cnt` +3. STEP with `cmd_arg`=0 → 1 commit.
- SYSCALL (0x0000000C) at 0x08 while in RUN → `pc_en`=0 at 0x08, `halt_cause`=4. In the same cycle, HALT + syscall hit → `halt_cause`=1.
- RUN issued while already in RUN → `cmd_err` is high for 1 cycle and the state is unchanged. CLEAR_STATS in a commit cycle → both counters read 0.
- `reset`=0 for 1 cycle during STEP with `step_left`=5 → `pc_en`=0 in that cycle, then HALTED with all registers at their reset values.
